mau_host_loader: RTL and testbench

Upstream feeder for the matrix algebra unit (`MAU`). Accepts a load command naming a target BRAM and a stream of MATRIX_DIM² bytes through a valid/ready interface, stages the whole matrix in a local buffer, then drives `host_instruction`/`data_in` into `MAU` with the LOAD opcode. It paces the bytes against `MAU`'s `busy_flag` and returns the instruction bus to NOP. This decouples a bursty host source (UART/bus bridge) from `MAU`'s one-byte-per-cycle load window.

---
 rtl/mau_host_loader_if.sv | 26 ++
 rtl/mau_host_loader.sv | 140 ++++++++++++++
 tb/tb_mau_host_loader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mau_host_loader_if.sv
// rtl/mau_host_loader_if.sv - host command/byte stream and MAU load bus bundle
interface mau_host_loader_if;
  logic       cmd_valid;
  logic [1:0] cmd_bram;
  logic       cmd_ready;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [7:0] host_instruction;
  logic [7:0] data_in;
  logic       busy_flag;
  logic       done;
  logic       error;

  // host side plus the MAU stub: drives commands, bytes and busy
  modport master (
    output cmd_valid, cmd_bram, s_valid, s_data, busy_flag,
    input  cmd_ready, s_ready, host_instruction, data_in, done, error
  );

  // loader side
  modport slave (
    input  cmd_valid, cmd_bram, s_valid, s_data, busy_flag,
    output cmd_ready, s_ready, host_instruction, data_in, done, error
  );
endinterface

// File: rtl/mau_host_loader.sv
// rtl/mau_host_loader.sv - stages one matrix from the host and streams it into MAU
module mau_host_loader #(
  parameter int MATRIX_DIM   = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  mau_host_loader_if.slave bus
);
  localparam int ELEMS = MATRIX_DIM * MATRIX_DIM;
  localparam int PTR_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ELEMS - 1);
  // the edge that would take the counter to BUSY_TIMEOUT is the timeout edge
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [7:0] OP_NOP = 8'h00;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_STREAM, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       bram_q, bram_nxt;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       instr_q, instr_nxt;
  logic [7:0]       data_q, data_nxt;
  logic             cmd_ready_q, s_ready_q, done_q, error_q, error_nxt;
  logic             wr_en;
  logic [7:0]       mem [ELEMS];

  function automatic logic [7:0] load_op(input logic [1:0] b);
    return {b, 2'b00, 2'b01, 2'b00};
  endfunction

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // registered outputs, pointers and timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bram_q      <= 2'd0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      instr_q     <= OP_NOP;
      data_q      <= 8'h00;
      cmd_ready_q <= 1'b1;
      s_ready_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      bram_q      <= bram_nxt;
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      cnt         <= cnt_nxt;
      instr_q     <= instr_nxt;
      data_q      <= data_nxt;
      cmd_ready_q <= (state_nxt == S_IDLE);
      s_ready_q   <= (state_nxt == S_FILL);
      done_q      <= (state_nxt == S_DONE);
      error_q     <= error_nxt;
    end
  end

  // staging buffer; contents survive reset and are simply overwritten by the next fill
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.s_data;
  end

  // next-state and next-output decode
  always_comb begin
    state_nxt  = state;
    bram_nxt   = bram_q;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    cnt_nxt    = cnt;
    instr_nxt  = instr_q;
    data_nxt   = data_q;
    error_nxt  = 1'b0;
    wr_en      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          bram_nxt   = bus.cmd_bram;
          wr_ptr_nxt = '0;
          state_nxt  = S_FILL;
        end
      end
      S_FILL: begin
        if (bus.s_valid && s_ready_q) begin
          wr_en      = 1'b1;
          wr_ptr_nxt = wr_ptr + 1'b1;
          if (wr_ptr == LAST_PTR) begin
            state_nxt = S_ISSUE;
            cnt_nxt   = '0;
            instr_nxt = load_op(bram_q);
            // a one-element matrix has its only byte still on the source bus
            data_nxt  = (wr_ptr == '0) ? bus.s_data : mem[0];
          end
        end
      end
      S_ISSUE: begin
        if (bus.busy_flag) begin
          state_nxt  = S_STREAM;
          rd_ptr_nxt = '0;
          instr_nxt  = OP_NOP;
          data_nxt   = mem[0];
        end else if (cnt == LAST_CNT) begin
          state_nxt = S_IDLE;
          error_nxt = 1'b1;
          cnt_nxt   = '0;
          instr_nxt = OP_NOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_STREAM: begin
        if (bus.busy_flag) begin
          // park on the last byte if MAU keeps busy up longer than the matrix
          if (rd_ptr != LAST_PTR) rd_ptr_nxt = rd_ptr + 1'b1;
          data_nxt = mem[rd_ptr_nxt];
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.cmd_ready        = cmd_ready_q;
  assign bus.s_ready          = s_ready_q;
  assign bus.host_instruction = instr_q;
  assign bus.data_in          = data_q;
  assign bus.done             = done_q;
  assign bus.error            = error_q;
endmodule

// File: tb/tb_mau_host_loader.sv
// tb/tb_mau_host_loader.sv - scoreboard bench with a behavioural MAU stub
module tb_mau_host_loader;
  localparam int ELEMS = 64;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mau_host_loader_if bus ();

  mau_host_loader #(.MATRIX_DIM(8), .BUSY_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit           is_err;
    logic [1:0]   bram;
    logic [511:0] data;
    int           load_cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  logic [511:0] stub_ram[4];
  logic [511:0] ref_ram[4];
  bit           no_busy = 1'b0;
  int           stub_j = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // MAU stub: on LOAD, raise busy after a random delay, then capture one byte per cycle
  initial begin : mau_stub
    int         phase;
    int         dly;
    logic [1:0] sb;
    phase = 0;
    dly = 0;
    sb = 2'd0;
    bus.busy_flag = 1'b0;
    for (int b = 0; b < 4; b++) begin
      stub_ram[b] = '0;
      ref_ram[b]  = '0;
    end
    forever begin
      @(negedge clk);
      if (!rst) begin
        phase = 0;
        bus.busy_flag = 1'b0;
      end else begin
        case (phase)
          0: if (bus.host_instruction != 8'h00 && !no_busy) begin
               sb    = bus.host_instruction[7:6];
               dly   = int'($urandom_range(0, 8));
               phase = 1;
             end
          1: if (dly == 0) begin
               bus.busy_flag = 1'b1;
               stub_j = 0;
               phase  = 2;
             end else begin
               dly--;
             end
          default: begin
            stub_ram[sb][stub_j*8 +: 8] = bus.data_in;
            stub_j++;
            if (stub_j == ELEMS) begin
              bus.busy_flag = 1'b0;
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  // monitor: pops the scoreboard whenever done or error is presented
  initial begin : monitor
    logic [7:0] prev_hi;
    logic [7:0] load_op;
    int         load_cyc;
    exp_t       e;
    prev_hi = 8'h00;
    load_op = 8'h00;
    load_cyc = -1;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        prev_hi = 8'h00;
      end else begin
        if (bus.host_instruction != 8'h00 && prev_hi == 8'h00) begin
          load_cyc = cyc;
          load_op  = bus.host_instruction;
        end
        prev_hi = bus.host_instruction;
        if (bus.done === 1'b1 || bus.error === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got done=%0b error=%0b, required no pending load",
                     bus.done, bus.error);
          end else begin
            e = exp_q.pop_front();
            chk("result_kind", 512'(bus.error), 512'(e.is_err));
            chk("load_opcode", 512'(load_op), 512'(int'(e.bram) * 64 + 4));
            chk("issue_cycle", 512'(load_cyc), 512'(e.load_cyc));
            if (e.is_err) begin
              chk("timeout_delay", 512'(cyc - load_cyc), 512'(TMO));
              chk("nop_after_error", 512'(bus.host_instruction), 512'(0));
              chk("cmd_ready_after_error", 512'(bus.cmd_ready), 512'(1));
            end else begin
              ref_ram[e.bram] = e.data;
            end
            for (int b = 0; b < 4; b++)
              chk($sformatf("bram%0d", b), stub_ram[b], ref_ram[b]);
          end
        end
      end
    end
  end

  // mode 0: source always valid, 1: valid every other cycle, 2: random valid
  task automatic do_load(input logic [1:0] b, input logic [511:0] d, input int mode, input bit expect_err);
    int   n;
    int   i;
    int   last;
    bit   valid;
    exp_t e;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_bram  = b;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cmd_accept_timeout: got cmd_ready=%0b, required 1", bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_bram  = 2'($urandom);
    i = 0;
    n = 0;
    last = 0;
    while (i < ELEMS && n < 1000) begin
      if (mode == 0)      valid = 1'b1;
      else if (mode == 1) valid = (n % 2 == 0);
      else                valid = 1'($urandom_range(0, 1));
      bus.s_valid = valid;
      bus.s_data  = valid ? d[i*8 +: 8] : 8'($urandom);
      if (valid && bus.s_ready === 1'b1) begin
        last = cyc;
        i++;
      end
      @(negedge clk);
      n++;
    end
    chk("s_ready_after_fill", 512'(bus.s_ready), 512'(0));
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hEE;
    e.is_err   = expect_err;
    e.bram     = b;
    e.data     = d;
    e.load_cyc = last + 1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 800) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : driver
    logic [511:0] d;
    int           n;
    bus.cmd_valid = 1'b0;
    bus.cmd_bram  = 2'd0;
    bus.s_valid   = 1'b0;
    bus.s_data    = 8'h00;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_host_instr", 512'(bus.host_instruction), 512'(0));
    chk("rst_data_in", 512'(bus.data_in), 512'(0));
    chk("rst_cmd_ready", 512'(bus.cmd_ready), 512'(1));
    chk("rst_s_ready", 512'(bus.s_ready), 512'(0));
    chk("rst_done_error", 512'({bus.done, bus.error}), 512'(0));
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_host_instr", 512'(bus.host_instruction), 512'(0));
    chk("idle_cmd_ready", 512'(bus.cmd_ready), 512'(1));
    chk("idle_s_ready", 512'(bus.s_ready), 512'(0));

    for (int i = 0; i < ELEMS; i++) d[i*8 +: 8] = 8'(i);
    do_load(2'd2, d, 0, 1'b0);
    wait_drain();

    for (int i = 0; i < ELEMS; i++) d[i*8 +: 8] = 8'h81;
    for (int b = 0; b < 4; b++) begin
      do_load(2'(b), d, 0, 1'b0);
      wait_drain();
    end

    for (int i = 0; i < ELEMS; i++) d[i*8 +: 8] = 8'(63 - i);
    do_load(2'd1, d, 1, 1'b0);
    wait_drain();

    no_busy = 1'b1;
    for (int i = 0; i < ELEMS; i++) d[i*8 +: 8] = 8'($urandom);
    do_load(2'd3, d, 0, 1'b1);
    wait_drain();
    no_busy = 1'b0;

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < ELEMS; i++) d[i*8 +: 8] = 8'($urandom);
      do_load(2'($urandom), d, 2, 1'b0);
    end
    wait_drain();

    for (int i = 0; i < ELEMS; i++) d[i*8 +: 8] = 8'($urandom);
    do_load(2'd0, d, 0, 1'b0);
    n = 0;
    while (!(bus.busy_flag === 1'b1 && stub_j >= 20) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stream_start_timeout: got %0d bytes, required 20", stub_j);
    end
    rst = 1'b0;
    #1;
    chk("midrst_host_instr", 512'(bus.host_instruction), 512'(0));
    chk("midrst_data_in", 512'(bus.data_in), 512'(0));
    chk("midrst_cmd_ready", 512'(bus.cmd_ready), 512'(1));
    chk("midrst_s_ready", 512'(bus.s_ready), 512'(0));
    chk("midrst_done_error", 512'({bus.done, bus.error}), 512'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < ELEMS; i++) d[i*8 +: 8] = 8'($urandom);
    do_load(2'd0, d, 0, 1'b0);
    wait_drain();

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
